game_sequencer: RTL and testbench

- Top-level game flow controller for the 2048 board.
- Chooses what the display shows: the attract/welcome grid or the live board.
- Owns the live board register and sequences each turn: button to move request, move engine handshake, random tile spawn, then win/game-over check.
- Sits between button conditioning, the welcome animation block, the move engine and the VGA renderer.

---
 rtl/game_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// 2048 game flow controller: owns the live board, sequences move/spawn/check turns
// and selects the welcome or live grid for the renderer.
module game_sequencer #(
    parameter int ANIMATION_DELAY = 30,
    parameter int SPAWN_TRIES     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_rising_edge,
    input  logic [3:0]  btn,
    input  logic [3:0]  lfsr_out,
    input  logic [63:0] welcome_grid,
    input  logic [63:0] move_grid,
    input  logic        move_changed,
    input  logic        move_done,
    output logic        move_start,
    output logic [1:0]  move_dir,
    output logic [63:0] board,
    output logic [63:0] display_grid,
    output logic        game_over,
    output logic        won
);

    localparam int TRY_W   = $clog2(SPAWN_TRIES + 1);
    localparam int FRAME_W = $clog2(ANIMATION_DELAY + 1);
    localparam logic [TRY_W-1:0]   TRY_LAST  = TRY_W'(SPAWN_TRIES - 1);
    localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(ANIMATION_DELAY);

    typedef enum logic [2:0] {
        S_WELCOME,
        S_SPAWN,
        S_CHECK,
        S_IDLE,
        S_MOVE,
        S_OVER,
        S_WON
    } state_t;

    state_t              state, state_nxt;
    logic [63:0]         board_nxt, display_nxt;
    logic [1:0]          spawn_left, spawn_left_nxt;
    logic [TRY_W-1:0]    tries, tries_nxt;
    logic [FRAME_W-1:0]  frame_cnt, frame_cnt_nxt;
    logic                move_start_nxt, game_over_nxt, won_nxt;
    logic [1:0]          move_dir_nxt;

    logic [3:0]          cells [16];
    logic                any_empty, has_2048, has_pair, found;
    logic [3:0]          first_empty;

    always_comb begin
        any_empty   = 1'b0;
        has_2048    = 1'b0;
        has_pair    = 1'b0;
        found       = 1'b0;
        first_empty = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            cells[i] = board[4*i +: 4];
        end
        for (int unsigned i = 0; i < 16; i++) begin
            if (cells[i] == 4'd0) begin
                any_empty = 1'b1;
                if (!found) begin
                    first_empty = 4'(i);
                    found       = 1'b1;
                end
            end
            if (cells[i] == 4'd11) has_2048 = 1'b1;
        end
        // a: position along the line, b: which row/column
        for (int unsigned b = 0; b < 4; b++) begin
            for (int unsigned a = 0; a < 3; a++) begin
                if (cells[4*b + a] == cells[4*b + a + 1]) has_pair = 1'b1;
                if (cells[4*a + b] == cells[4*a + b + 4]) has_pair = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_WELCOME;
            board        <= '0;
            display_grid <= '0;
            spawn_left   <= '0;
            tries        <= '0;
            frame_cnt    <= '0;
            move_start   <= 1'b0;
            move_dir     <= '0;
            game_over    <= 1'b0;
            won          <= 1'b0;
        end else begin
            state        <= state_nxt;
            board        <= board_nxt;
            display_grid <= display_nxt;
            spawn_left   <= spawn_left_nxt;
            tries        <= tries_nxt;
            frame_cnt    <= frame_cnt_nxt;
            move_start   <= move_start_nxt;
            move_dir     <= move_dir_nxt;
            game_over    <= game_over_nxt;
            won          <= won_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        board_nxt      = board;
        spawn_left_nxt = spawn_left;
        tries_nxt      = tries;
        frame_cnt_nxt  = frame_cnt;
        unique case (state)
            S_WELCOME: begin
                if (|btn) begin
                    board_nxt      = '0;
                    spawn_left_nxt = 2'd2;
                    tries_nxt      = '0;
                    state_nxt      = S_SPAWN;
                end
            end
            S_SPAWN: begin
                if (!any_empty) begin
                    spawn_left_nxt = '0;
                end else if (cells[lfsr_out] == 4'd0) begin
                    board_nxt[{lfsr_out, 2'b00} +: 4] = (lfsr_out == 4'hF) ? 4'd2 : 4'd1;
                    spawn_left_nxt = spawn_left - 2'd1;
                    tries_nxt      = '0;
                end else if (tries == TRY_LAST) begin
                    // the failed attempt that exhausts the budget falls back in the same cycle
                    board_nxt[{first_empty, 2'b00} +: 4] = 4'd1;
                    spawn_left_nxt = spawn_left - 2'd1;
                    tries_nxt      = '0;
                end else begin
                    tries_nxt = tries + TRY_W'(1);
                end
                if (spawn_left_nxt == 2'd0) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                frame_cnt_nxt = '0;
                if (has_2048)                     state_nxt = S_WON;
                else if (!any_empty && !has_pair) state_nxt = S_OVER;
                else                              state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (|btn) state_nxt = S_MOVE;
            end
            S_MOVE: begin
                // a completion coincident with our own request pulse is not ours yet
                if (move_done && !move_start) begin
                    if (move_changed) begin
                        board_nxt      = move_grid;
                        spawn_left_nxt = 2'd1;
                        tries_nxt      = '0;
                        state_nxt      = S_SPAWN;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_OVER, S_WON: begin
                if (vsync_rising_edge && frame_cnt != FRAME_MAX)
                    frame_cnt_nxt = frame_cnt + FRAME_W'(1);
                if (|btn && frame_cnt == FRAME_MAX) state_nxt = S_WELCOME;
            end
            default: state_nxt = S_WELCOME;
        endcase
    end

    always_comb begin
        move_start_nxt = (state == S_IDLE) && (|btn);
        move_dir_nxt   = move_dir;
        if (state == S_IDLE) begin
            if (btn[3])      move_dir_nxt = 2'd0;
            else if (btn[2]) move_dir_nxt = 2'd1;
            else if (btn[1]) move_dir_nxt = 2'd2;
            else if (btn[0]) move_dir_nxt = 2'd3;
        end
        game_over_nxt = (state_nxt == S_OVER);
        won_nxt       = (state_nxt == S_WON);
        display_nxt   = (state == S_WELCOME) ? welcome_grid : board;
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed + randomized bench for game_sequencer; the bench plays the move engine
// and tracks the expected board with a cell-array model of the game rules.
module tb_game_sequencer;

    localparam int AD = 30;

    logic        clk = 1'b0;
    logic        rst, vsync_rising_edge, move_changed, move_done;
    logic [3:0]  btn, lfsr_out;
    logic [63:0] welcome_grid, move_grid;
    logic        move_start, game_over, won;
    logic [1:0]  move_dir;
    logic [63:0] board, display_grid;

    game_sequencer #(.ANIMATION_DELAY(AD), .SPAWN_TRIES(16)) dut (
        .clk(clk), .rst(rst), .vsync_rising_edge(vsync_rising_edge),
        .btn(btn), .lfsr_out(lfsr_out), .welcome_grid(welcome_grid),
        .move_grid(move_grid), .move_changed(move_changed), .move_done(move_done),
        .move_start(move_start), .move_dir(move_dir), .board(board),
        .display_grid(display_grid), .game_over(game_over), .won(won)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] m [16];
    int left, fails;
    logic [3:0] lfsr_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack();
        logic [63:0] p;
        for (int i = 0; i < 16; i++) p[4*i +: 4] = m[i];
        return p;
    endfunction

    function automatic void unpack(input logic [63:0] g);
        for (int i = 0; i < 16; i++) m[i] = g[4*i +: 4];
    endfunction

    function automatic int n_empty();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m[i] == 0) n++;
        return n;
    endfunction

    function automatic bit m_2048();
        for (int i = 0; i < 16; i++) if (m[i] == 11) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_pair();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (c < 3 && m[r*4+c] == m[r*4+c+1]) return 1'b1;
                if (r < 3 && m[r*4+c] == m[(r+1)*4+c]) return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic logic [1:0] prio(input logic [3:0] b);
        if (b[3]) return 2'd0;
        if (b[2]) return 2'd1;
        if (b[1]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [63:0] rand_grid();
        logic [63:0] g;
        int a;
        for (int i = 0; i < 16; i++) g[4*i +: 4] = 4'($urandom_range(0, 10));
        a = $urandom_range(0, 15);
        g[4*a +: 4] = 4'd0;
        g[4*((a+5)%16) +: 4] = 4'd0;
        g[4*((a+10)%16) +: 4] = 4'd0;
        return g;
    endfunction

    // One placement attempt in lockstep with the DUT.
    task automatic spawn_step(input logic [3:0] l);
        lfsr_out = l;
        tick();
        if (n_empty() == 0) begin
            left = 0;
        end else if (m[l] == 0) begin
            m[l] = (l == 4'hF) ? 4'd2 : 4'd1;
            left--;
            fails = 0;
        end else begin
            fails++;
            if (fails == 16) begin
                for (int k = 0; k < 16; k++)
                    if (m[k] == 0) begin
                        m[k] = 4'd1;
                        break;
                    end
                left--;
                fails = 0;
            end
        end
        check("spawn_step_board", board, pack());
    endtask

    task automatic run_spawn(input int n);
        int guard = 0;
        left  = n;
        fails = 0;
        while (left > 0 && guard < 200) begin
            spawn_step(lfsr_q.size() > 0 ? lfsr_q.pop_front() : 4'($urandom_range(0, 15)));
            guard++;
        end
        lfsr_out = 4'($urandom_range(0, 15));
        tick();
        check("check_won", won, m_2048());
        check("check_over", game_over, !m_2048() && n_empty() == 0 && !m_pair());
    endtask

    task automatic start_game();
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        for (int i = 0; i < 16; i++) m[i] = 4'd0;
        check("start_clear", board, 64'd0);
        run_spawn(2);
    endtask

    task automatic do_move(input logic [3:0] b, input logic [63:0] g, input bit chg, input int lat);
        btn = b;
        tick();
        btn = 4'b0000;
        check("move_start_pulse", move_start, 1'b1);
        check("move_dir", move_dir, prio(b));
        btn = 4'($urandom_range(1, 15));
        tick();
        btn = 4'b0000;
        check("move_start_drop", move_start, 1'b0);
        repeat (lat - 1) begin
            btn = 4'($urandom_range(1, 15));
            tick();
            btn = 4'b0000;
            check("move_no_restart", move_start, 1'b0);
        end
        move_done    = 1'b1;
        move_changed = chg;
        move_grid    = g;
        tick();
        move_done    = 1'b0;
        move_changed = 1'b0;
        check("move_dir_held", move_dir, prio(b));
        if (chg) begin
            unpack(g);
            check("move_board", board, g);
            run_spawn(1);
        end else begin
            check("move_nochange", board, pack());
        end
    endtask

    task automatic frames_then_btn(input int n);
        repeat (n) begin
            vsync_rising_edge = 1'b1;
            tick();
            vsync_rising_edge = 1'b0;
        end
        btn = 4'b0100;
        tick();
        btn = 4'b0000;
    endtask

    logic [63:0] g, full_pat;

    initial begin
        rst = 1'b1; vsync_rising_edge = 1'b0; move_changed = 1'b0; move_done = 1'b0;
        btn = 4'b0000; lfsr_out = 4'd0; move_grid = '0;
        welcome_grid = 64'h0000_0000_0B00_0000;
        tick();
        tick();
        check("rst_board", board, 64'd0);
        check("rst_display", display_grid, 64'd0);
        check("rst_move_start", move_start, 1'b0);
        check("rst_move_dir", move_dir, 2'd0);
        check("rst_game_over", game_over, 1'b0);
        check("rst_won", won, 1'b0);
        rst = 1'b0;
        tick();
        check("welcome_display", display_grid, 64'h0000_0000_0B00_0000);
        repeat (3) tick();
        welcome_grid = 64'h0123_4567_89AB_CDEF;
        tick();
        check("welcome_follow", display_grid, 64'h0123_4567_89AB_CDEF);
        check("welcome_board", board, 64'd0);

        lfsr_q = '{4'd3, 4'd3, 4'd7};
        start_game();
        check("first_spawn", board, 64'h0000_0000_1000_1000);
        check("idle_display", display_grid, pack());

        g = pack();
        g[3:0] = 4'd2;
        lfsr_q = '{4'hF};
        do_move(4'b1010, g, 1'b1, 2);
        check("spawn_value2", {60'd0, board[63:60]}, 64'd2);

        // completion coincident with the request pulse is ignored
        btn = 4'b0100;
        tick();
        btn = 4'b0000;
        check("coinc_start", move_start, 1'b1);
        move_done = 1'b1; move_changed = 1'b1; move_grid = rand_grid();
        tick();
        move_done = 1'b0; move_changed = 1'b0;
        check("coinc_ignored", board, pack());
        tick();
        tick();
        move_done = 1'b1;
        tick();
        move_done = 1'b0;
        check("nochange_board", board, pack());
        do_move(4'b0001, rand_grid(), 1'b0, 3);

        g = 64'h0000_0000_0040_0333;
        lfsr_q.delete();
        repeat (16) lfsr_q.push_back(4'd5);
        do_move(4'b0010, g, 1'b1, 1);
        check("fallback_cell3", board, 64'h0000_0000_0040_1333);

        for (int t = 0; t < 20; t++)
            do_move(4'($urandom_range(1, 15)), rand_grid(), ($urandom_range(0, 3) != 0),
                    $urandom_range(1, 4));

        for (int i = 0; i < 16; i++)
            full_pat[4*i +: 4] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;
        g = full_pat;
        g[3:0] = 4'd0;
        lfsr_q = '{4'd0};
        do_move(4'b1000, g, 1'b1, 1);
        check("over_flag", game_over, 1'b1);

        for (int i = 0; i < AD - 1; i++) begin
            vsync_rising_edge = 1'b1;
            tick();
            vsync_rising_edge = 1'b0;
            btn = 4'b0001;
            tick();
            btn = 4'b0000;
            check("over_hold", game_over, 1'b1);
        end
        vsync_rising_edge = 1'b1;
        btn = 4'b0001;
        tick();
        vsync_rising_edge = 1'b0;
        btn = 4'b0000;
        check("over_sat_btn", game_over, 1'b1);
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        check("over_exit", game_over, 1'b0);
        tick();
        check("back_welcome", display_grid, welcome_grid);

        start_game();
        g = full_pat;
        g[3:0] = 4'd0;
        g[23:20] = 4'd11;
        lfsr_q = '{4'd0};
        do_move(4'b0100, g, 1'b1, 2);
        check("won_flag", won, 1'b1);
        check("won_not_over", game_over, 1'b0);
        btn = 4'b0010;
        tick();
        btn = 4'b0000;
        check("won_btn_early", won, 1'b1);

        frames_then_btn(AD);
        check("won_exit", won, 1'b0);
        start_game();
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        check("abort_start", move_start, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        move_done = 1'b1; move_changed = 1'b1; move_grid = rand_grid();
        tick();
        move_done = 1'b0; move_changed = 1'b0;
        check("late_done_board", board, 64'd0);
        check("late_done_start", move_start, 1'b0);
        tick();
        check("late_done_display", display_grid, welcome_grid);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
